// File: rtl/pit_multi_ch_if.sv
// pit_multi_ch_if -- Wishbone classic slave bus bundle for pit_multi_ch.
//   AW : address width ($clog2(CHANNELS)+3 for the timer)
//   DW : data width
// Signals: wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i driven by the master;
//          wb_dat_o, wb_ack_o driven by the slave.
interface pit_multi_ch_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic          wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/pit_multi_ch.sv
// pit_multi_ch -- multi-channel programmable interval timer with a shared prescaler.
// Ports:
//   wb_clk_i   : single clock, rising edge
//   wb_rst_i   : synchronous active-high reset
//   wb         : Wishbone slave (pit_multi_ch_if.slave), one wait state per access
//   pit_o      : per-channel one-cycle terminal pulse
//   pit_irq_o  : OR over channels of FLAG & IEN
//   pre_tick_o : one-cycle prescaler tick
// Address map: adr MSB=1 -> global {0 PRE_MOD, 1 FLAGS(W1C)}; MSB=0 -> {ch, reg}
//   reg 0 CTRL {4 CASCADE, 3 FLAG(RO), 2 IEN, 1 ONESHOT, 0 EN}, 1 MOD, 2 CNT(RO).
// Build option: define PIT_MULTI_CASCADE_EN to let channel n>0 count the
//   terminal events of channel n-1; otherwise CASCADE reads 0 and is ignored.
module pit_multi_ch #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_SIZE = 16,
    parameter int PRE_SIZE   = 16,
    parameter int DWIDTH     = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    pit_multi_ch_if.slave       wb,
    output logic [CHANNELS-1:0] pit_o,
    output logic                pit_irq_o,
    output logic                pre_tick_o
);
    localparam int AW = $clog2(CHANNELS) + 3;

    logic                  ack_q, ack_d;
    logic [DWIDTH-1:0]     dat_q, dat_d, rd_s;
    logic [PRE_SIZE-1:0]   pre_mod_q, pre_mod_d, pre_cnt_q, pre_cnt_d;
    logic                  pre_tick_s, pre_tick_q;
    logic [CHANNELS-1:0]   en_q, en_d, one_q, one_d, ien_q, ien_d;
    logic [CHANNELS-1:0]   flag_q, flag_d, casc_q, casc_d;
    logic [CHANNELS-1:0]   term_s, pit_q;
    logic                  irq_q, irq_d;
    logic [COUNT_SIZE-1:0] mod_q [CHANNELS];
    logic [COUNT_SIZE-1:0] mod_d [CHANNELS];
    logic [COUNT_SIZE-1:0] cnt_q [CHANNELS];
    logic [COUNT_SIZE-1:0] cnt_d [CHANNELS];

    logic          req_s, wr_s, glob_s;
    logic [1:0]    reg_s;
    logic [AW-1:0] ch_sel_s;

    assign req_s    = wb.wb_stb_i & wb.wb_cyc_i;
    // Writes commit on the ack cycle, while the master still holds the request.
    assign wr_s     = ack_q & req_s & wb.wb_we_i;
    assign glob_s   = wb.wb_adr_i[AW-1];
    assign reg_s    = wb.wb_adr_i[1:0];
    // Channel index; the global-space MSB lands in the top bit and is excluded by glob_s.
    assign ch_sel_s = wb.wb_adr_i >> 2;

    // Bus handshake: single ack one cycle after the request, never back to back.
    always_comb begin
        ack_d = req_s & ~ack_q;
        if (req_s && !ack_q) begin
            dat_d = rd_s;
        end else begin
            dat_d = {DWIDTH{1'b0}};
        end
    end

    // Register read multiplexer; narrow fields are zero-extended.
    always_comb begin
        rd_s = {DWIDTH{1'b0}};
        if (glob_s) begin
            case (reg_s)
                2'd0:    rd_s = DWIDTH'(pre_mod_q);
                2'd1:    rd_s = DWIDTH'(flag_q);
                default: rd_s = {DWIDTH{1'b0}};
            endcase
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (ch_sel_s == AW'(n)) begin
                    case (reg_s)
                        2'd0:    rd_s = DWIDTH'({casc_q[n], flag_q[n], ien_q[n], one_q[n], en_q[n]});
                        2'd1:    rd_s = DWIDTH'(mod_q[n]);
                        2'd2:    rd_s = DWIDTH'(cnt_q[n]);
                        default: rd_s = {DWIDTH{1'b0}};
                    endcase
                end else begin
                    rd_s = rd_s;
                end
            end
        end
    end

    // Shared prescaler: wraps at PRE_MOD-1; a PRE_MOD write restarts it without a tick.
    always_comb begin
        pre_mod_d  = pre_mod_q;
        pre_cnt_d  = pre_cnt_q;
        pre_tick_s = 1'b0;
        if (wr_s && glob_s && reg_s == 2'd0) begin
            pre_mod_d = wb.wb_dat_i[PRE_SIZE-1:0];
            pre_cnt_d = {PRE_SIZE{1'b0}};
        end else if (pre_mod_q <= PRE_SIZE'(1)) begin
            pre_cnt_d  = {PRE_SIZE{1'b0}};
            pre_tick_s = 1'b1;
        end else if (pre_cnt_q == pre_mod_q - PRE_SIZE'(1)) begin
            pre_cnt_d  = {PRE_SIZE{1'b0}};
            pre_tick_s = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_SIZE'(1);
        end
    end

    // Channel counters, control writes, terminal events and flag W1C.
    always_comb begin
        logic ctrl_wr;
        logic mod_wr;
        logic tick;
`ifdef PIT_MULTI_CASCADE_EN
        logic prev_term;
        prev_term = 1'b0;
`endif
        for (int n = 0; n < CHANNELS; n++) begin
            en_d[n]   = en_q[n];
            one_d[n]  = one_q[n];
            ien_d[n]  = ien_q[n];
            flag_d[n] = flag_q[n];
            casc_d[n] = casc_q[n];
            mod_d[n]  = mod_q[n];
            cnt_d[n]  = cnt_q[n];
            term_s[n] = 1'b0;
            ctrl_wr   = wr_s && !glob_s && (ch_sel_s == AW'(n)) && (reg_s == 2'd0);
            mod_wr    = wr_s && !glob_s && (ch_sel_s == AW'(n)) && (reg_s == 2'd1);
            if (ctrl_wr) begin
                en_d[n]  = wb.wb_dat_i[0];
                one_d[n] = wb.wb_dat_i[1];
                ien_d[n] = wb.wb_dat_i[2];
`ifdef PIT_MULTI_CASCADE_EN
                casc_d[n] = (n > 0) ? wb.wb_dat_i[4] : 1'b0;
`else
                casc_d[n] = 1'b0;
`endif
                // Rising EN loads the modulo; no tick is taken this cycle since en_q is 0.
                if (!en_q[n] && wb.wb_dat_i[0]) begin
                    cnt_d[n] = mod_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n];
                end
            end else begin
                en_d[n] = en_q[n];
            end
            if (mod_wr) begin
                mod_d[n] = wb.wb_dat_i[COUNT_SIZE-1:0];
            end else begin
                mod_d[n] = mod_q[n];
            end
`ifdef PIT_MULTI_CASCADE_EN
            tick = casc_q[n] ? prev_term : pre_tick_s;
`else
            tick = pre_tick_s;
`endif
            // W1C first so that a terminal event in the same cycle wins.
            if (wr_s && glob_s && reg_s == 2'd1 && wb.wb_dat_i[n]) begin
                flag_d[n] = 1'b0;
            end else begin
                flag_d[n] = flag_q[n];
            end
            // en_d gates the tick so a software clear freezes CNT immediately.
            if (en_q[n] && en_d[n] && tick) begin
                if (cnt_q[n] <= COUNT_SIZE'(1)) begin
                    term_s[n] = 1'b1;
                    flag_d[n] = 1'b1;
                    if (one_d[n]) begin
                        cnt_d[n] = {COUNT_SIZE{1'b0}};
                        en_d[n]  = 1'b0;
                    end else begin
                        cnt_d[n] = mod_q[n];
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] - COUNT_SIZE'(1);
                end
            end else begin
                term_s[n] = 1'b0;
            end
`ifdef PIT_MULTI_CASCADE_EN
            prev_term = term_s[n];
`endif
        end
    end

    // Interrupt follows the next-state flags so it tracks FLAG & IEN without extra lag.
    always_comb begin
        irq_d = |(flag_d & ien_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= {DWIDTH{1'b0}};
            pre_mod_q  <= {PRE_SIZE{1'b0}};
            pre_cnt_q  <= {PRE_SIZE{1'b0}};
            pre_tick_q <= 1'b0;
            en_q       <= {CHANNELS{1'b0}};
            one_q      <= {CHANNELS{1'b0}};
            ien_q      <= {CHANNELS{1'b0}};
            flag_q     <= {CHANNELS{1'b0}};
            casc_q     <= {CHANNELS{1'b0}};
            pit_q      <= {CHANNELS{1'b0}};
            irq_q      <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                mod_q[n] <= {COUNT_SIZE{1'b0}};
                cnt_q[n] <= {COUNT_SIZE{1'b0}};
            end
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            pre_mod_q  <= pre_mod_d;
            pre_cnt_q  <= pre_cnt_d;
            pre_tick_q <= pre_tick_s;
            en_q       <= en_d;
            one_q      <= one_d;
            ien_q      <= ien_d;
            flag_q     <= flag_d;
            casc_q     <= casc_d;
            pit_q      <= term_s;
            irq_q      <= irq_d;
            for (int n = 0; n < CHANNELS; n++) begin
                mod_q[n] <= mod_d[n];
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign pit_o       = pit_q;
    assign pit_irq_o   = irq_q;
    assign pre_tick_o  = pre_tick_q;
endmodule

// File: tb/tb_pit_multi_ch.sv
// tb_pit_multi_ch -- self-checking bench for pit_multi_ch (4 channels, 16-bit).
// Read expectations and pulse-period expectations are queued when stimulus is
// applied and popped when the DUT acknowledges a read or emits a pulse.
`timescale 1ns/1ps
module tb_pit_multi_ch;
    localparam int CH = 4;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam logic [4:0] A_PRE   = 5'h10;
    localparam logic [4:0] A_FLAGS = 5'h11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] pit;
    logic          irq;
    logic          ptick;

    pit_multi_ch_if #(.AW(AW), .DW(DW)) bus ();

    pit_multi_ch #(.CHANNELS(CH), .COUNT_SIZE(16), .PRE_SIZE(16), .DWIDTH(DW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (bus),
        .pit_o      (pit),
        .pit_irq_o  (irq),
        .pre_tick_o (ptick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] rd_exp_q [$];
    string       rd_tag_q [$];
    int          p0_exp [$];
    int          p1_exp [$];
    int          cyc_n = 0;
    int          last0 = -1;
    int          last1 = -1;
    int          pc0 = 0;
    int          pc1 = 0;
    logic        prev_ack = 1'b0;
    logic        prev_p0 = 1'b0;
    logic        prev_p1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ca(input int c, input int r);
        return 5'(c * 4 + r);
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Output monitor: ack spacing, pulse width, and pulse periods against the queues.
    always @(negedge clk) begin
        if (bus.wb_ack_o) check("ack_single", {31'd0, prev_ack}, 32'd0);
        if (pit[0]) begin
            check("pit0_width", {31'd0, prev_p0}, 32'd0);
            pc0++;
            if (last0 >= 0 && p0_exp.size() > 0) check("pit0_period", cyc_n - last0, p0_exp.pop_front());
            last0 = cyc_n;
        end
        if (pit[1]) begin
            check("pit1_width", {31'd0, prev_p1}, 32'd0);
            pc1++;
            if (last1 >= 0 && p1_exp.size() > 0) check("pit1_period", cyc_n - last1, p1_exp.pop_front());
            last1 = cyc_n;
        end
        prev_ack = bus.wb_ack_o;
        prev_p0  = pit[0];
        prev_p1  = pit[1];
    end

    task automatic wb_xfer(input logic [4:0] adr, input logic [15:0] wd, input logic we,
                           input bit scored, output logic [15:0] rd);
        bit          got;
        string       t;
        logic [15:0] e;
        got = 1'b0;
        rd  = 16'h0;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wd;
        bus.wb_we_i  = we;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o) begin
                got = 1'b1;
                rd  = bus.wb_dat_o;
            end
        end
        if (scored) begin
            e = rd_exp_q.pop_front();
            t = rd_tag_q.pop_front();
            if (got) check(t, rd, e);
            else     check({t, "_ack_timeout"}, 32'd0, 32'd1);
        end else if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [15:0] wd);
        logic [15:0] d;
        wb_xfer(adr, wd, 1'b1, 1'b0, d);
    endtask

    task automatic rd_chk(input logic [4:0] adr, input logic [15:0] e, input string tag);
        logic [15:0] d;
        rd_exp_q.push_back(e);
        rd_tag_q.push_back(tag);
        wb_xfer(adr, 16'h0, 1'b0, 1'b1, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int          prev;
        int          t0;
        int          base;
        int          cnt_exp [$];
        bus.wb_adr_i = 5'h0;
        bus.wb_dat_i = 16'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst_pit", {28'd0, pit}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ptick", {31'd0, ptick}, 32'd0);
        check("rst_dat", {16'd0, bus.wb_dat_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_chk(A_PRE, 16'h0, "rst_pre_mod");
        rd_chk(A_FLAGS, 16'h0, "rst_flags");
        rd_chk(ca(0, 0), 16'h0, "rst_ctrl0");
        rd_chk(ca(0, 1), 16'h0, "rst_mod0");
        rd_chk(ca(0, 2), 16'h0, "rst_cnt0");

        // Unmapped registers read zero
        wr(5'h12, 16'hFFFF);
        rd_chk(5'h12, 16'h0, "glob_reg2_zero");
        wr(ca(0, 3), 16'hFFFF);
        rd_chk(ca(0, 3), 16'h0, "ch0_reg3_zero");

        // Periodic channel 0: PRE_MOD=3, MOD=4 -> 12-cycle period, CNT 4,3,2,1,4
        wr(A_PRE, 16'd3);
        wr(ca(0, 1), 16'd4);
        rd_chk(ca(0, 1), 16'd4, "ch0_mod_rb");
        repeat (3) p0_exp.push_back(12);
        cnt_exp = '{4, 3, 2, 1, 4};
        wr(ca(0, 0), 16'h0001);
        prev = -1;
        for (int i = 0; i < 40 && cnt_exp.size() > 0; i++) begin
            wb_xfer(ca(0, 2), 16'h0, 1'b0, 1'b0, rd);
            if (int'(rd) != prev) begin
                prev = int'(rd);
                check("ch0_cnt_seq", rd, cnt_exp.pop_front());
            end
        end
        check("ch0_cnt_seq_done", cnt_exp.size(), 0);
        for (int i = 0; i < 100 && p0_exp.size() > 0; i++) @(posedge clk);
        #1;
        check("pit0_periods_done", p0_exp.size(), 0);
        wr(ca(0, 0), 16'h0000);
        wr(A_FLAGS, 16'h0001);
        rd_chk(A_FLAGS, 16'h0, "flags_w1c_ch0");

        // One-shot channel 1: PRE_MOD=0, MOD=2
        wr(A_PRE, 16'd0);
        wr(ca(1, 1), 16'd2);
        base = pc1;
        wr(ca(1, 0), 16'h0003);
        t0 = cyc_n;
        repeat (10) @(posedge clk);
        #1;
        check("ch1_oneshot_lat", last1 - t0, 2);
        check("ch1_oneshot_count", pc1 - base, 1);
        rd_chk(ca(1, 0), 16'h000A, "ch1_ctrl_after");
        rd_chk(ca(1, 2), 16'h0, "ch1_cnt_after");
        rd_chk(A_FLAGS, 16'h0002, "flags_ch1");

        // Flag set beats a coincident W1C; clean W1C drops irq
        wr(A_FLAGS, 16'h0002);
        rd_chk(A_FLAGS, 16'h0, "flags_w1c_ch1");
        wr(ca(2, 1), 16'd1);
        wr(ca(2, 0), 16'h0005);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        wr(A_FLAGS, 16'h0004);
        @(negedge clk);
        check("irq_hold_coincident", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        rd_chk(A_FLAGS, 16'h0004, "flags_set_wins");
        rd_chk(ca(2, 0), 16'h000D, "ch2_ctrl_flag");
        wr(ca(2, 0), 16'h0004);
        @(negedge clk);
        check("irq_after_disable", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        wr(A_FLAGS, 16'h0004);
        @(negedge clk);
        check("irq_clear", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        rd_chk(A_FLAGS, 16'h0, "flags_clean_clear");

        // Cascade bit and cascade period
        wr(ca(0, 0), 16'h0010);
        rd_chk(ca(0, 0), 16'h0000, "ch0_casc_ro0");
        wr(ca(1, 0), 16'h0010);
`ifdef PIT_MULTI_CASCADE_EN
        rd_chk(ca(1, 0), 16'h0010, "ch1_casc_rb");
`else
        rd_chk(ca(1, 0), 16'h0000, "ch1_casc_rb");
`endif
        wr(ca(1, 1), 16'd3);
        wr(ca(0, 1), 16'd10);
        last1 = -1;
`ifdef PIT_MULTI_CASCADE_EN
        repeat (2) p1_exp.push_back(30);
`else
        repeat (2) p1_exp.push_back(3);
`endif
        wr(ca(1, 0), 16'h0011);
        wr(ca(0, 0), 16'h0001);
        for (int i = 0; i < 150 && p1_exp.size() > 0; i++) @(posedge clk);
        #1;
        check("pit1_periods_done", p1_exp.size(), 0);
        wr(ca(0, 0), 16'h0000);
        wr(ca(1, 0), 16'h0000);

        // Reset during an active count and a pending ack
        wr(A_PRE, 16'd3);
        wr(ca(0, 1), 16'd5);
        wr(ca(0, 0), 16'h0001);
        repeat (20) @(posedge clk);
        #1;
        bus.wb_adr_i = ca(0, 1);
        bus.wb_we_i  = 1'b0;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst2_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst2_pit", {28'd0, pit}, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        check("rst2_ptick", {31'd0, ptick}, 32'd0);
        check("rst2_dat", {16'd0, bus.wb_dat_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        rst = 1'b0;
        rd_chk(A_PRE, 16'h0, "rst2_pre_mod");
        rd_chk(A_FLAGS, 16'h0, "rst2_flags");
        rd_chk(ca(0, 0), 16'h0, "rst2_ctrl0");
        rd_chk(ca(0, 1), 16'h0, "rst2_mod0");
        rd_chk(ca(0, 2), 16'h0, "rst2_cnt0");
        rd_chk(ca(2, 0), 16'h0, "rst2_ctrl2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pit_multi_ch.md
PIT_MULTI_CH -- requirements
Module: pit_multi_ch

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter COUNT_SIZE, default 16, width of each channel counter and modulo (<= DWIDTH).
REQ-003 SHALL have parameter PRE_SIZE, default 16, width of the shared prescaler counter and modulo (<= DWIDTH).
REQ-004 SHALL have parameter DWIDTH, default 16, Wishbone data bus width.
REQ-005 SHALL have port wb_clk_i  in  1  the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port wb_adr_i  in  $clog2(CHANNELS)+3  address: bit MSB=1 global space, MSB=0 channel space {ch, reg[1:0]}.
REQ-008 SHALL have ports wb_dat_i in DWIDTH, wb_dat_o out DWIDTH, wb_we_i in 1, wb_stb_i in 1, wb_cyc_i in 1, wb_ack_o out 1.
REQ-009 SHALL have port pit_o  out  CHANNELS  per-channel one-cycle terminal pulse.
REQ-010 SHALL have port pit_irq_o  out  1  OR over channels of (FLAG & IEN).
REQ-011 SHALL have port pre_tick_o  out  1  one-cycle prescaler tick.

Function
REQ-012 Global regs SHALL be: 0 PRE_MOD (RW), 1 FLAGS (bit n = channel n FLAG; write 1 clears, write 0 no effect); others read 0.
REQ-013 Channel regs SHALL be: 0 CTRL {bit0 EN, bit1 ONESHOT, bit2 IEN, bit3 FLAG (RO here), bit4 CASCADE}, 1 MOD (RW), 2 CNT (RO), 3 reads 0.
REQ-014 Prescaler SHALL count 0..PRE_MOD-1 every cycle and assert pre_tick_o for one cycle when wrapping; PRE_MOD 0 or 1 gives a tick every cycle.
REQ-015 A PRE_MOD write SHALL clear the prescaler counter the same cycle; the first tick follows PRE_MOD cycles later.
REQ-016 EN 0->1 write SHALL load CNT=MOD in the write cycle; no tick is consumed that cycle.
REQ-017 On a channel tick with EN=1: if CNT<=1 it is a terminal event, else CNT decrements by 1.
REQ-018 Terminal event SHALL set FLAG, pulse pit_o[n] the following cycle for exactly one cycle, and reload CNT=MOD (ONESHOT=0) or set CNT=0 and clear EN (ONESHOT=1).
REQ-019 MOD writes while running SHALL take effect only at the next reload or enable.
REQ-020 FLAG set and W1C clear in the same cycle: set SHALL win.
REQ-021 EN cleared by software SHALL freeze CNT; FLAG is unaffected.
REQ-022 Wishbone: wb_ack_o SHALL assert one cycle after stb&cyc and deassert the next cycle (one wait state, never consecutive acks); write committed on the ack cycle; wb_dat_o valid on the ack cycle, 0 otherwise.
REQ-023 Register fields narrower than DWIDTH SHALL read zero-extended; unused write bits ignored.

Reset
REQ-024 wb_rst_i SHALL clear, at the next edge, all CTRL, MOD, CNT, PRE_MOD, prescaler counter and flags; wb_ack_o, pit_o, pit_irq_o, pre_tick_o, wb_dat_o read 0.
REQ-025 Reset mid-transaction SHALL drop the pending ack; the master must retry.

Configuration
REQ-026 Macro PIT_MULTI_CASCADE_EN defined: channel n>0 with CASCADE=1 SHALL use channel n-1 terminal events as its tick instead of pre_tick_o.
REQ-027 PIT_MULTI_CASCADE_EN undefined: CASCADE bit SHALL read 0, writes ignored, all channels use pre_tick_o; channel 0 CASCADE always reads 0.

Verification
REQ-028 PRE_MOD=3, ch0 MOD=4 periodic EN=1 -> pit_o[0] pulses every 12 cycles; CNT sequence 4,3,2,1,4.
REQ-029 ch1 ONESHOT=1, MOD=2, PRE_MOD=0 -> one pit_o[1] pulse after 2 ticks, EN reads 0, CNT reads 0, no further pulses.
REQ-030 IEN=1 terminal event then W1C to FLAGS coincident with another terminal -> FLAG stays 1, pit_irq_o stays 1; clean W1C -> pit_irq_o 0 next cycle.
REQ-031 With PIT_MULTI_CASCADE_EN, ch0 MOD=10 periodic, ch1 CASCADE MOD=3 -> pit_o[1] every 30 ticks; without macro ch1 CASCADE reads 0.
REQ-032 Assert wb_rst_i during an active ch0 count and during a pending ack -> all registers 0, no ack, pit_o 0 next cycle.
